inst_prefetch_buffer: RTL

- Instruction prefetch stage between the synchronous instruction SRAM (1-cycle read latency) and the fetch stage of the 5-stage MIPS pipeline.
- Generates sequential fetch addresses and keeps up to DEPTH {pc, inst} pairs in a FIFO.
- Presents the head entry to the fetch stage with a valid/ready handshake.
- Flushes the buffer and restarts fetch on a branch/jump/exception redirect.

---
 rtl/inst_prefetch_buffer_pkg.sv | 12 +
 rtl/inst_prefetch_buffer_fifo.sv | 50 +++++
 rtl/inst_prefetch_buffer.sv | 78 +++++++
 3 files changed

// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared fetch-path constants and the {pc, inst} entry carried by the prefetch buffer.
// Pure declarations: no latency, no flow control.
package inst_prefetch_buffer_pkg;
  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ibuf_entry_t;
endpackage

// File: rtl/inst_prefetch_buffer_fifo.sv
// ibuf_fifo: DEPTH-entry storage with head/tail/count; push lands next edge, head is combinational.
// No internal backpressure: the caller guarantees no push when full and no pop when empty; clear wins.
module ibuf_fifo
  import inst_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_push,
  input  ibuf_entry_t             i_push_dat,
  input  logic                    i_pop,
  output ibuf_entry_t             o_head_dat,
  output logic [$clog2(DEPTH):0]  o_count
);
  localparam int AW = $clog2(DEPTH);

  ibuf_entry_t   r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_push_dat;
        r_tail        <= r_tail + AW'(1);
      end
      if (i_pop) r_head <= r_head + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_dat = r_mem[r_head];
  assign o_count    = r_count;
endmodule

// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetch into a DEPTH-entry buffer; SRAM data is buffered the cycle after issue.
// Issues only when a slot is guaranteed (credit = count + inflight - pop); redirect flushes and restarts.
module inst_prefetch_buffer
  import inst_prefetch_buffer_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    redirect_valid,
  input  logic [PC_W-1:0]         redirect_pc,
  output logic                    inst_sram_en,
  output logic [PC_W-1:0]         inst_sram_addr,
  input  logic [INST_W-1:0]       inst_sram_rdata,
  output logic                    ibuf_valid,
  input  logic                    ibuf_ready,
  output logic [PC_W-1:0]         ibuf_pc,
  output logic [INST_W-1:0]       ibuf_inst,
  output logic [$clog2(DEPTH):0]  ibuf_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_req_pc;
  logic            r_inflight;
  logic            r_kill;

  logic            w_pop;
  logic            w_push;
  logic [CW:0]     w_occ;
  ibuf_entry_t     w_push_dat;
  ibuf_entry_t     w_head;

  assign w_pop  = ibuf_valid && ibuf_ready && !redirect_valid;
  assign w_push = r_inflight && !r_kill;
  assign w_occ  = {1'b0, ibuf_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};

  // rst_n gating keeps the SRAM idle while reset is held; the first fetch goes out on the first edge after release.
  assign inst_sram_en   = rst_n && !redirect_valid && (w_occ < (CW+1)'(DEPTH));
  assign inst_sram_addr = r_fetch_pc;
  assign w_push_dat     = {r_req_pc, inst_sram_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
      r_kill     <= r_inflight;
    end else begin
      r_kill     <= 1'b0;
      r_inflight <= inst_sram_en;
      if (inst_sram_en) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_req_pc   <= r_fetch_pc;
      end
    end
  end

  ibuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clear    (redirect_valid),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (ibuf_count)
  );

  assign ibuf_valid = (ibuf_count != '0);
  assign ibuf_pc    = w_head.pc;
  assign ibuf_inst  = w_head.inst;
endmodule
